// File: rtl/d_mem_pkg.sv
// d_mem_pkg: shared types and helpers for the handshaked data memory.
//   state_t   - handshake FSM states (IDLE, WAIT, RESP)
//   lanes_of  - byte lanes in a word of the given width
//   idx_w     - bits needed to index DEPTH words (at least 1)
//   ERR_CODE  - value driven on resp_err for a failed access
package d_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int lanes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam logic ERR_CODE = 1'b1;

endpackage

// File: rtl/d_mem_array.sv
// d_mem_array: word storage for d_mem_hs. Contents are set only at time zero
// (word i = i when INIT_INDEX=1, else 0) and are never reset.
//   clk   - clock
//   we    - write strobe; lanes with be[k]=1 take wdata byte k
//   be    - byte-lane enables
//   idx   - word index shared by read and write
//   wdata - write data
//   re    - read strobe; loads rdata from the addressed word
//   rdata - registered read data, held until the next read strobe
module d_mem_array
  import d_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int INIT_INDEX = 1,
  localparam int LANES     = lanes_of(DATA_WIDTH),
  localparam int IW        = idx_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LANES-1:0]      be,
  input  logic [IW-1:0]         idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata
);

  typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (INIT_INDEX != 0) ? DATA_WIDTH'(i) : '0;
    end
    return m;
  endfunction

  mem_t mem = init_mem();
  logic [DATA_WIDTH-1:0] rdata_p1 = '0;

  // Stage p0 -> p1: byte-lane write commit and read capture on the same edge;
  // the read returns the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < LANES; k++) begin
        if (be[k]) begin
          mem[idx][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
    if (re) begin
      rdata_p1 <= mem[idx];
    end
  end

  assign rdata = rdata_p1;

endmodule

// File: rtl/d_mem_hs.sv
// d_mem_hs: synchronous data memory with valid/ready request and response
// handshakes, byte-enable writes, READ_LATENCY (1..4) cycles from acceptance
// to resp_valid, and error reporting for misaligned/out-of-range accesses.
// One request is outstanding at a time; the response is held until taken.
//   clk, rst_n             - clock, asynchronous active-low reset
//   req_valid/req_ready    - request handshake
//   req_we, req_addr       - write flag, byte address
//   req_be, req_wdata      - byte-lane enables and write data
//   resp_valid/resp_ready  - response handshake
//   resp_rdata, resp_err   - read data (0 for writes/errors), error flag
module d_mem_hs
  import d_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int INIT_INDEX   = 1,
  localparam int LANES       = lanes_of(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LANES-1:0]      req_be,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int IW = idx_w(DEPTH);
  localparam int LB = (LANES > 1) ? $clog2(LANES) : 0;
  // WAIT holds for CNT_LD+1 cycles, so RESP is entered READ_LATENCY edges
  // after acceptance.
  localparam logic [1:0] CNT_LD = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  state_t state, state_nx;
  logic [1:0] cnt;
  logic rdy_en;
  logic we_p1, err_p1;

  logic [ADDR_WIDTH-1:0] word_full;
  logic mis, oor, req_err, acc;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Stage p0: address decode and acceptance.
  assign word_full = req_addr >> LB;
  assign mis       = (req_addr & ADDR_WIDTH'(LANES - 1)) != '0;
  assign oor       = word_full >= ADDR_WIDTH'(DEPTH);
  assign req_err   = mis | oor;
  assign acc       = req_valid & req_ready;

  d_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_INDEX (INIT_INDEX)
  ) u_array (
    .clk   (clk),
    .we    (acc & req_we & ~req_err),
    .be    (req_be),
    .idx   (word_full[IW-1:0]),
    .wdata (req_wdata),
    .re    (acc & ~req_we & ~req_err),
    .rdata (arr_rdata)
  );

  // Stage p0 -> p1: state, latency counter and captured request kind.
  // rdy_en keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rdy_en <= 1'b0;
      we_p1  <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      state  <= state_nx;
      rdy_en <= 1'b1;
      if (acc) begin
        we_p1  <= req_we;
        err_p1 <= req_err;
        cnt    <= CNT_LD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (acc) state_nx = (READ_LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == '0) state_nx = RESP;
      RESP: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p1: response outputs; data and error are zero outside RESP.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state)
      IDLE: req_ready = rdy_en;
      RESP: begin
        resp_valid = 1'b1;
        if (err_p1) resp_err = ERR_CODE;
        else if (!we_p1) resp_rdata = arr_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_d_mem_hs.sv
module tb_d_mem_hs;

  logic        clk;
  logic        rst1_n, rst3_n;
  logic        v1, v3;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  be_i;
  logic [31:0] wd_i;
  logic        rr_i;
  logic        rdy1, rdy3, val1, val3, er1, er3;
  logic [31:0] rd1, rd3;

  int n_chk  = 0;
  int n_fail = 0;

  d_mem_hs #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .READ_LATENCY(1), .INIT_INDEX(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .req_valid(v1), .req_ready(rdy1), .req_we(we_i),
    .req_addr(addr_i), .req_be(be_i), .req_wdata(wd_i), .resp_valid(val1),
    .resp_ready(rr_i), .resp_rdata(rd1), .resp_err(er1));

  d_mem_hs #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .READ_LATENCY(3), .INIT_INDEX(1)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_ready(rdy3), .req_we(we_i),
    .req_addr(addr_i), .req_be(be_i), .req_wdata(wd_i), .resp_valid(val3),
    .resp_ready(rr_i), .resp_rdata(rd3), .resp_err(er3));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Issue one request to the selected DUT with resp_ready held high.
  task automatic do_req(input bit s3, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    rd = '0; er = 1'b0; lat = 0;
    @(negedge clk);
    we_i = we; addr_i = addr; be_i = be; wd_i = wd; rr_i = 1'b1;
    if (s3) v3 = 1'b1; else v1 = 1'b1;
    n = 0;
    while (!(s3 ? rdy3 : rdy1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      v1 = 1'b0; v3 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    v1 = 1'b0; v3 = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(s3 ? val3 : val1) && lat < 20);
    rd = s3 ? rd3 : rd1;
    er = s3 ? er3 : er1;
    chk("req_ready_in_resp", {31'd0, s3 ? rdy3 : rdy1}, 32'd0);
    @(posedge clk);
    #1;
    chk("resp_consumed", {31'd0, s3 ? val3 : val1}, 32'd0);
  endtask

  // Accept a request on the latency-3 DUT, then reset it while in WAIT.
  task automatic abort_in_wait(input logic we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wd);
    @(negedge clk);
    we_i = we; addr_i = addr; be_i = be; wd_i = wd; rr_i = 1'b1; v3 = 1'b1;
    chk("abort_ready_before", {31'd0, rdy3}, 32'd1);
    @(posedge clk);
    #1;
    v3 = 1'b0;
    @(negedge clk);
    chk("abort_in_wait_valid", {31'd0, val3}, 32'd0);
    chk("abort_in_wait_ready", {31'd0, rdy3}, 32'd0);
    rst3_n = 1'b0;
    #1;
    chk("abort_rst_rdata", rd3, 32'd0);
    chk("abort_rst_err", {31'd0, er3}, 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_resp", {31'd0, val3}, 32'd0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] exp;
    int          n;

    vecs[0]  = '{1'b0, 32'h14,  4'h0, 32'h0,        32'h00000005, 1'b0};
    vecs[1]  = '{1'b1, 32'h20,  4'h3, 32'hAABBCCDD, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'h20,  4'h0, 32'h0,        32'h0000CCDD, 1'b0};
    vecs[3]  = '{1'b0, 32'h22,  4'h0, 32'h0,        32'h0,        1'b1};
    vecs[4]  = '{1'b0, 32'h400, 4'h0, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{1'b1, 32'h400, 4'hF, 32'hDEADBEEF, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h10,  4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h10,  4'h0, 32'h0,        32'h00000004, 1'b0};
    vecs[8]  = '{1'b0, 32'h3FC, 4'h0, 32'h0,        32'h000000FF, 1'b0};
    vecs[9]  = '{1'b1, 32'h3FC, 4'hC, 32'h12345678, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h3FC, 4'h0, 32'h0,        32'h123400FF, 1'b0};
    vecs[11] = '{1'b1, 32'h23,  4'hF, 32'h11111111, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'h20,  4'h0, 32'h0,        32'h0000CCDD, 1'b0};
    vecs[13] = '{1'b1, 32'h24,  4'h4, 32'h00990000, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 32'h24,  4'h0, 32'h0,        32'h00990009, 1'b0};
    vecs[15] = '{1'b0, 32'h0,   4'h0, 32'h0,        32'h00000000, 1'b0};
    vecs[16] = '{1'b1, 32'h401, 4'hF, 32'h22222222, 32'h0,        1'b1};

    clk = 1'b0; rst1_n = 1'b0; rst3_n = 1'b0; v1 = 1'b0; v3 = 1'b0;
    we_i = 1'b0; addr_i = '0; be_i = '0; wd_i = '0; rr_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, rdy1}, 32'd0);
    chk("rst_resp_valid", {31'd0, val1}, 32'd0);
    chk("rst_resp_rdata", rd1, 32'd0);
    chk("rst_resp_err", {31'd0, er1}, 32'd0);
    chk("rst_req_ready3", {31'd0, rdy3}, 32'd0);
    rst1_n = 1'b1; rst3_n = 1'b1;
    #1;
    chk("ready_before_first_edge", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    chk("ready_after_first_edge", {31'd0, rdy1}, 32'd1);
    chk("ready_after_first_edge3", {31'd0, rdy3}, 32'd1);

    // Vector table on the latency-1 DUT
    for (int i = 0; i < 17; i++) begin
      do_req(1'b0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wd, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_latency", i), lat, 32'd1);
    end

    // Full sweep: only the legally written words differ from their index
    for (int i = 0; i < 256; i++) begin
      do_req(1'b0, 1'b0, 32'(i * 4), 4'h0, 32'h0, rd, er, lat);
      case (i)
        8:       exp = 32'h0000CCDD;
        9:       exp = 32'h00990009;
        255:     exp = 32'h123400FF;
        default: exp = 32'(i);
      endcase
      chk($sformatf("sweep_word%0d", i), rd, exp);
    end

    // Latency 3 with a stalled consumer
    @(negedge clk);
    we_i = 1'b0; addr_i = 32'h14; be_i = 4'h0; rr_i = 1'b0; v3 = 1'b1;
    chk("stall_ready_before", {31'd0, rdy3}, 32'd1);
    @(posedge clk);
    #1;
    v3 = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk($sformatf("stall_wait%0d_valid", c), {31'd0, val3}, 32'd0);
      chk($sformatf("stall_wait%0d_ready", c), {31'd0, rdy3}, 32'd0);
    end
    @(negedge clk);
    chk("stall_valid_at_3", {31'd0, val3}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("stall_hold%0d_valid", c), {31'd0, val3}, 32'd1);
      chk($sformatf("stall_hold%0d_rdata", c), rd3, 32'd5);
      chk($sformatf("stall_hold%0d_err", c), {31'd0, er3}, 32'd0);
      chk($sformatf("stall_hold%0d_ready", c), {31'd0, rdy3}, 32'd0);
    end
    rr_i = 1'b1;
    @(negedge clk);
    chk("stall_done_valid", {31'd0, val3}, 32'd0);
    chk("stall_done_rdata", rd3, 32'd0);
    chk("stall_done_ready", {31'd0, rdy3}, 32'd1);

    do_req(1'b1, 1'b0, 32'h2C, 4'h0, 32'h0, rd, er, lat);
    chk("lat3_rdata", rd, 32'd11);
    chk("lat3_latency", lat, 32'd3);

    // Reset during WAIT: read is dropped, memory untouched
    abort_in_wait(1'b0, 32'h18, 4'h0, 32'h0);
    do_req(1'b1, 1'b0, 32'h18, 4'h0, 32'h0, rd, er, lat);
    chk("after_abort_read_rdata", rd, 32'd6);
    chk("after_abort_read_latency", lat, 32'd3);

    // Reset during WAIT after a write: the write is already committed
    abort_in_wait(1'b1, 32'h1C, 4'hF, 32'h00000055);
    do_req(1'b1, 1'b0, 32'h1C, 4'h0, 32'h0, rd, er, lat);
    chk("after_abort_write_rdata", rd, 32'h00000055);

    // Back-to-back on latency 1: request held valid is taken every 2 cycles
    @(negedge clk);
    we_i = 1'b0; addr_i = 32'h4; rr_i = 1'b1; v1 = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      if (v1 && rdy1) n++;
      @(negedge clk);
      chk($sformatf("b2b_cycle%0d_valid", c), {31'd0, val1}, (c % 2 == 0) ? 32'd1 : 32'd0);
    end
    v1 = 1'b0;
    chk("b2b_accept_count", n, 32'd3);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
